// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe
//   Registered ready/valid ShiftRows / InvShiftRows stage for a Rijndael datapath
//   with NB state columns (4, 6 or 8). A 2-entry elastic buffer (main + skid
//   register) keeps in_ready registered, so there is no combinational ready path
//   from out_ready back to in_ready.
//
//   Byte (r,c) sits at in_state[8*(r*NB+c) +: 8] on an ascending [0:W-1] vector,
//   which makes byte 0 the most-significant byte of the bus.
//
// Ports
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready     input handshake; in_ready is a registered "not FULL"
//   in_inv                  per-beat direction: 0 = rotate rows left, 1 = right
//   in_state                input state, W = 32*NB bits
//   out_valid / out_ready   output handshake; out_valid = occupancy != EMPTY
//   out_state               oldest buffered beat (main register)
//   xfer_cnt                completed output transfers, wraps at 2^CNT_W
module shift_rows_pipe #(
  parameter int NB    = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_inv,
  input  logic [0:32*NB-1]  in_state,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:32*NB-1]  out_state,
  output logic [CNT_W-1:0]  xfer_cnt
);

  localparam int unsigned NBU = NB;
  localparam int unsigned W   = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_nb_check
    $fatal(1, "shift_rows_pipe: NB must be 4, 6 or 8");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e             state_q, state_d;
  logic [0:W-1]     main_q, main_d;
  logic [0:W-1]     skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [0:W-1]     shifted;
  logic             accept, deliver;

  // Row rotation amounts: rows 2 and 3 move one further for 8-column blocks.
  function automatic int unsigned row_off(input int unsigned r);
    if (NBU == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  // Both directions use loop-constant byte indices, so this reduces to a
  // per-byte 2:1 mux controlled by in_inv.
  always_comb begin
    shifted = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < NBU; c++) begin
        shifted[8*(r*NBU+c) +: 8] = in_inv
          ? in_state[8*(r*NBU + (c + NBU - row_off(r)) % NBU) +: 8]
          : in_state[8*(r*NBU + (c + row_off(r)) % NBU) +: 8];
      end
    end
  end

  always_comb begin
    accept     = in_valid & in_ready_q;
    deliver    = (state_q != EMPTY) & out_ready;
    state_d    = state_q;
    main_d     = main_q;
    skid_d     = skid_q;
    cnt_d      = cnt_q + CNT_W'(deliver);
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = shifted;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          main_d = shifted;
        end else if (accept) begin
          skid_d  = shifted;
          state_d = FULL;
        end else if (deliver) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the drain side can move.
        if (deliver) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_state = main_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb_shift_rows_pipe
//   Three instances (NB = 4 with a 4-bit counter, NB = 6, NB = 8) share one clock
//   and reset. A monitor predicts each accepted beat with a byte-rotation model
//   and checks delivered beats in FIFO order; the main thread drives directed
//   vectors, backpressure, random traffic, reset-in-FULL and counter wrap.
module tb_shift_rows_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]   vin, irdy, inv, vout, ordy;
  logic [0:255] din  [3];
  logic [0:255] dout [3];
  logic [15:0]  cnt  [3];

  int n_tests = 0;
  int n_fail  = 0;
  int deliv [3];
  logic [0:255] q0 [$];
  logic [0:255] q1 [$];
  logic [0:255] q2 [$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NBG = (g == 0) ? 4 : (g == 1) ? 6 : 8;
    localparam int CW  = (g == 0) ? 4 : 16;
    localparam int WG  = 32 * NBG;
    logic [0:WG-1] so;
    logic [CW-1:0] c;
    shift_rows_pipe #(.NB(NBG), .CNT_W(CW)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (vin[g]),
      .in_ready  (irdy[g]),
      .in_inv    (inv[g]),
      .in_state  (din[g][0:WG-1]),
      .out_valid (vout[g]),
      .out_ready (ordy[g]),
      .out_state (so),
      .xfer_cnt  (c)
    );
    assign dout[g] = 256'(so) << (256 - WG);
    assign cnt[g]  = 16'(c);
  end

  function automatic int nb_of(input int g);
    return (g == 0) ? 4 : (g == 1) ? 6 : 8;
  endfunction

  function automatic int cnt_mask(input int g);
    return (g == 0) ? 15 : 65535;
  endfunction

  // Reference: each row r is rotated by its offset, left or right, as bytes.
  function automatic logic [0:255] ref_shift(input logic [0:255] s, input logic iv, input int nb);
    logic [0:255] o;
    int off, src;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      off = (nb == 8 && r >= 2) ? r + 1 : r;
      for (int c = 0; c < nb; c++) begin
        src = iv ? (c - off + nb) % nb : (c + off) % nb;
        o[8*(r*nb+c) +: 8] = s[8*(r*nb+src) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [0:255] rand_state(input int nb);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r & ~({256{1'b1}} >> (32 * nb));
  endfunction

  function automatic int qsize(input int g);
    case (g)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qpush(input int g, input logic [0:255] v);
    case (g)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic qpop(input int g, output logic [0:255] v);
    case (g)
      0:       v = q0.pop_front();
      1:       v = q1.pop_front();
      default: v = q2.pop_front();
    endcase
  endtask

  task automatic qclear(input int g);
    case (g)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Inputs change at posedge+1, so the falling edge sees the handshakes that
  // the next rising edge will act on.
  task automatic monitor();
    logic [0:255] e;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (!rst_n) begin
          qclear(g);
          deliv[g] = 0;
        end else begin
          if (vout[g] && ordy[g]) begin
            n_tests++;
            if (qsize(g) == 0) begin
              n_fail++;
              $display("FAIL sb_nb%0d: out_state %0h delivered with nothing pending", nb_of(g), dout[g]);
            end else begin
              qpop(g, e);
              if (dout[g] !== e) begin
                n_fail++;
                $display("FAIL sb_nb%0d: out_state got %0h expected %0h", nb_of(g), dout[g], e);
              end
            end
            deliv[g]++;
          end
          if (vin[g] && irdy[g]) qpush(g, ref_shift(din[g], inv[g], nb_of(g)));
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [0:255] b1, b2, b3;
    int cyc;
    vin = '0; inv = '0; ordy = '0;
    for (int g = 0; g < 3; g++) begin
      din[g]   = '0;
      deliv[g] = 0;
    end
    fork
      monitor();
    join_none

    // Reset state
    #12;
    chk("rst_in_ready", 256'(irdy), 256'(3'b000));
    chk("rst_out_valid", 256'(vout), 256'(3'b000));
    for (int g = 0; g < 3; g++) begin
      chk("rst_out_state", dout[g], '0);
      chk("rst_xfer_cnt", 256'(cnt[g]), '0);
    end
    #10 rst_n = 1'b1;
    tick();
    chk("in_ready_after_release", 256'(irdy), 256'(3'b111));

    // NB=4 forward vector
    din[0] = {128'h00010203_04050607_08090a0b_0c0d0e0f, 128'h0};
    inv[0] = 1'b0; vin[0] = 1'b1; ordy[0] = 1'b1;
    tick();
    vin[0] = 1'b0;
    chk("t1_out_valid", 256'(vout[0]), 256'(1'b1));
    chk("t1_out_state", dout[0], {128'h00010203_05060704_0a0b0809_0f0c0d0e, 128'h0});
    tick();
    chk("t1_xfer_cnt", 256'(cnt[0]), 256'(1));
    chk("t1_drained", 256'(vout[0]), 256'(1'b0));

    // NB=4 inverse vector
    din[0] = {128'h00010203_05060704_0a0b0809_0f0c0d0e, 128'h0};
    inv[0] = 1'b1; vin[0] = 1'b1;
    tick();
    vin[0] = 1'b0;
    chk("t2_out_state", dout[0], {128'h00010203_04050607_08090a0b_0c0d0e0f, 128'h0});
    tick();
    chk("t2_xfer_cnt", 256'(cnt[0]), 256'(2));

    // NB=8 forward: row offsets 0,1,3,4
    din[2] = 256'h0001020304050607_08090a0b0c0d0e0f_1011121314151617_18191a1b1c1d1e1f;
    inv[2] = 1'b0; vin[2] = 1'b1; ordy[2] = 1'b1;
    tick();
    vin[2] = 1'b0;
    chk("t3_nb8_fwd", dout[2], 256'h0001020304050607_090a0b0c0d0e0f08_1314151617101112_1c1d1e1f18191a1b);
    tick();

    // Backpressure on NB=4: three beats offered, two taken, mixed directions
    b1 = rand_state(4); b2 = rand_state(4); b3 = rand_state(4);
    ordy[0] = 1'b0;
    din[0] = b1; inv[0] = 1'b0; vin[0] = 1'b1;
    tick();
    chk("t4_ready_after_1", 256'(irdy[0]), 256'(1'b1));
    din[0] = b2; inv[0] = 1'b1;
    tick();
    chk("t4_ready_after_2", 256'(irdy[0]), 256'(1'b0));
    chk("t4_hold_a", dout[0], ref_shift(b1, 1'b0, 4));
    din[0] = b3; inv[0] = 1'b0;
    tick();
    chk("t4_ready_full", 256'(irdy[0]), 256'(1'b0));
    chk("t4_hold_b", dout[0], ref_shift(b1, 1'b0, 4));
    ordy[0] = 1'b1;
    tick();
    chk("t4_second", dout[0], ref_shift(b2, 1'b1, 4));
    chk("t4_second_valid", 256'(vout[0]), 256'(1'b1));
    chk("t4_ready_reopen", 256'(irdy[0]), 256'(1'b1));
    tick();
    vin[0] = 1'b0;
    chk("t4_third", dout[0], ref_shift(b3, 1'b0, 4));
    chk("t4_third_valid", 256'(vout[0]), 256'(1'b1));
    tick();
    chk("t4_empty", 256'(vout[0]), 256'(1'b0));

    // Random traffic on all three widths
    cyc = 0;
    while ((deliv[0] < 10000 || deliv[1] < 10000 || deliv[2] < 10000) && cyc < 50000) begin
      for (int g = 0; g < 3; g++) begin
        vin[g]  = 1'($urandom_range(0, 1));
        ordy[g] = 1'($urandom_range(0, 1));
        inv[g]  = 1'($urandom_range(0, 1));
        din[g]  = rand_state(nb_of(g));
      end
      tick();
      cyc++;
    end
    n_tests++;
    if (cyc >= 50000) begin
      n_fail++;
      $display("FAIL random_budget: delivered %0d/%0d/%0d required 10000 each", deliv[0], deliv[1], deliv[2]);
    end
    vin = '0; ordy = '1;
    repeat (4) tick();
    for (int g = 0; g < 3; g++) begin
      chk("random_drained", 256'(qsize(g)), '0);
      chk("random_xfer_cnt", 256'(cnt[g]), 256'(deliv[g] & cnt_mask(g)));
    end

    // Reset while FULL and stalled
    vin = '1; ordy = '0;
    repeat (3) begin
      for (int g = 0; g < 3; g++) din[g] = rand_state(nb_of(g));
      tick();
    end
    chk("t6_full", 256'(irdy), 256'(3'b000));
    #1 rst_n = 1'b0;
    #1;
    chk("t6_out_valid", 256'(vout), 256'(3'b000));
    chk("t6_in_ready", 256'(irdy), 256'(3'b000));
    for (int g = 0; g < 3; g++) begin
      chk("t6_xfer_cnt", 256'(cnt[g]), '0);
      chk("t6_out_state", dout[g], '0);
    end
    vin = '0;
    #20 rst_n = 1'b1;
    tick();
    chk("t6_ready_release", 256'(irdy), 256'(3'b111));
    repeat (3) begin
      chk("t6_no_stale", 256'(vout), 256'(3'b000));
      tick();
    end

    // 4-bit counter wrap: 17 deliveries
    vin[0] = 1'b1; ordy[0] = 1'b1;
    repeat (17) begin
      din[0] = rand_state(4);
      inv[0] = 1'($urandom_range(0, 1));
      tick();
    end
    vin[0] = 1'b0;
    repeat (2) tick();
    chk("wrap_xfer_cnt", 256'(cnt[0]), 256'(1));
    for (int g = 0; g < 3; g++) chk("final_drained", 256'(qsize(g)), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
